demux_4_buffered: RTL and testbench
===================================

// Module: demux_4_buffered
// PURPOSE
//   Four-way 32-bit demultiplexer: the distribution-side counterpart of Mux_4.
//   Routes each input word, steered by a 2-bit select, into one of four
//   per-channel FIFOs. Each channel drains independently over its own
//   valid/ready handshake.
//   Sits between a single producer and four consumers. Per-channel word order
//   is preserved.
// PARAMETERS
//   WIDTH  32  data width of input and of each output channel
//   DEPTH  2   entries per channel FIFO; power of two, >= 2
// PORTS
//   clk        in   1          rising-edge clock, the only clock
//   reset_n    in   1          asynchronous active-low reset
//   in_data    in   WIDTH      word to route
//   in_select  in   2          destination: 0=a, 1=b, 2=c, 3=d
//   in_valid   in   1          in_data/in_select valid
//   in_ready   out  1          selected channel can accept this cycle
//   out_data   out  4*WIDTH    ch i on [i*WIDTH +: WIDTH]; head of FIFO i
//   out_valid  out  4          ch i FIFO non-empty
//   out_ready  in   4          consumer i takes head this cycle
//   out_full   out  4          ch i FIFO holds DEPTH words
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - all FIFOs empty, pointers and counts 0
//     - out_valid=0, out_full=0, out_data=0
//     - in_ready reflects empty FIFOs, i.e. 1 for any select
//     - reset mid-operation discards all stored words; no partial transfer
//       survives.
//   Push:
//     - in_ready = ~out_full[in_select], combinational from in_select and the
//       registered counts only; never depends on in_valid or out_ready.
//     - accept when in_valid & in_ready; word written to FIFO[in_select] at
//       that clock edge.
//     - in_valid with in_ready=0: nothing written; producer holds data/select.
//   Pop:
//     - FIFOs are first-word-fall-through: out_data slice i shows the head
//       whenever out_valid[i]=1.
//     - pop on out_valid[i] & out_ready[i]; out_ready[i] with out_valid[i]=0
//       is ignored.
//     - out_data slice i is 0 whenever FIFO i is empty.
//   Latency: a word accepted at edge N appears at out_valid/out_data at edge N
//     (visible in cycle N+1). Never earlier: no combinational in->out bypass.
//   Simultaneous events:
//     - push and pop on the same non-full, non-empty channel: count unchanged,
//       both occur.
//     - push to a full channel is refused even if that channel pops in the same
//       cycle (no full bypass): 1-cycle bubble by design.
//     - push on one channel and pops on any others in the same cycle: all occur
//       independently.
//   Pointers: rd/wr ptrs are log2(DEPTH) bits and wrap modulo DEPTH; count is
//     log2(DEPTH)+1 bits, range 0..DEPTH.
//   out_full[i] = (count_i == DEPTH); out_valid[i] = (count_i != 0); both
//     registered-derived and glitch-free.
//   Overflow and underflow are impossible by construction; no error flags.
// TESTING
//   1. Reset with in_valid=1 held -> out_valid=0000, out_data=0,
//      in_ready=1 for all selects.
//   2. Send aaaaaaaa/bbbbbbbb/cccccccc/dddddddd with sel 0..3, out_ready=0
//      -> out_valid=1111, slices a..d match.
//   3. Sel=1, out_ready=0; push 11111111 then 22222222 (DEPTH=2)
//      -> out_full[1]=1, in_ready=0; third word 33333333 refused.
//      Then out_ready[1]=1 -> reads 11111111 then 22222222 in order.
//   4. Ch2 holding 1 word, push abcdefff to sel 2 while out_ready[2]=1
//      -> count stays 1; next head abcdefff.
//   5. Ch0 full, out_ready[0]=1 and push to sel 0 in the same cycle
//      -> push refused (in_ready=0), pop occurs; next cycle in_ready=1.
//   6. Random sel/valid/ready for 10k cycles vs. 4-queue scoreboard
//      -> no loss, duplication or reordering. Async reset pulse mid-run
//      -> all out_valid drop immediately; scoreboard flushed.

Source files
------------

// File: rtl/demux_4_buffered.sv
// Four-way buffered demultiplexer: routes each input word by in_select into one of four
// first-word-fall-through FIFOs, each drained over its own valid/ready handshake.
module demux_4_buffered #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [1:0]         in_select,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [4*WIDTH-1:0] out_data,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [3:0]         out_full
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [3:0] push;
   logic [3:0] pop;

   // Ready looks only at registered fullness, so a same-cycle pop never frees a slot.
   assign in_ready = ~out_full[in_select];

   for (genvar ch = 0; ch < 4; ch++) begin : g_ch
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CntW-1:0]  cnt_q, cnt_d;

      assign push[ch] = in_valid & in_ready & (in_select == 2'(ch));
      assign pop[ch]  = out_valid[ch] & out_ready[ch];

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         cnt_d    = cnt_q;
         if (push[ch]) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
         end
         if (pop[ch]) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
         end
         unique case ({push[ch], pop[ch]})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
         endcase
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
               mem_q[e] <= '0;
            end
         end else if (push[ch]) begin
            mem_q[wr_ptr_q] <= in_data;
         end
      end

      assign out_valid[ch] = (cnt_q != '0);
      assign out_full[ch]  = (cnt_q == CntW'(DEPTH));
      // Empty channels present zero rather than a stale head.
      assign out_data[ch*WIDTH +: WIDTH] = out_valid[ch] ? mem_q[rd_ptr_q] : '0;
   end

endmodule

// File: tb/tb_demux_4_buffered.sv
// Bench for demux_4_buffered: directed vectors with literal expectations plus a
// four-queue reference model compared against every output on each falling edge.
module tb_demux_4_buffered;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 2;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [WIDTH-1:0]   in_data;
   logic [1:0]         in_select;
   logic               in_valid;
   logic               in_ready;
   logic [4*WIDTH-1:0] out_data;
   logic [3:0]         out_valid;
   logic [3:0]         out_ready;
   logic [3:0]         out_full;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   logic [31:0] mq [4][$];

   demux_4_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_select (in_select),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_full  (out_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int ch, input logic [31:0] act,
                      input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         $display("FAIL %s ch%0d: got %h want %h at %0t", name, ch, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model: one queue per channel, updated from pre-edge occupancy.
   always @(posedge clk) begin : m_upd
      bit       acc;
      bit [3:0] pp;
      if (!reset_n) begin
         for (int c = 0; c < 4; c++) mq[c].delete();
      end else begin
         acc = in_valid && (mq[in_select].size() < DEPTH);
         for (int c = 0; c < 4; c++) pp[c] = out_ready[c] && (mq[c].size() != 0);
         for (int c = 0; c < 4; c++) if (pp[c]) void'(mq[c].pop_front());
         if (acc) mq[in_select].push_back(in_data);
      end
   end

   always @(negedge reset_n) begin
      for (int c = 0; c < 4; c++) mq[c].delete();
   end

   // Compare process: every output against the model, every cycle.
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         chk("out_valid", c, 32'(out_valid[c]), 32'(mq[c].size() != 0));
         chk("out_full", c, 32'(out_full[c]), 32'(mq[c].size() == DEPTH));
         chk("out_data", c, out_data[c*WIDTH +: WIDTH],
             (mq[c].size() != 0) ? mq[c][0] : 32'h0);
      end
      chk("in_ready", int'(in_select), 32'(in_ready), 32'(mq[in_select].size() < DEPTH));
   end

   logic [31:0] pat [4];
   logic        pend;

   initial begin
      pat[0] = 32'haaaaaaaa; pat[1] = 32'hbbbbbbbb;
      pat[2] = 32'hcccccccc; pat[3] = 32'hdddddddd;
      reset_n   = 1'b0;
      in_valid  = 1'b1;
      in_select = 2'd0;
      in_data   = 32'hdeadbeef;
      out_ready = 4'h0;

      // 1: reset with in_valid held
      tick; tick;
      chk("rst_valid", 0, 32'(out_valid), 32'h0);
      for (int c = 0; c < 4; c++) chk("rst_data", c, out_data[c*WIDTH +: WIDTH], 32'h0);
      for (int s = 0; s < 4; s++) begin
         in_select = 2'(s);
         #1;
         chk("rst_in_ready", s, 32'(in_ready), 32'h1);
      end
      reset_n  = 1'b1;
      in_valid = 1'b0;
      tick;

      // 2: one word to each channel
      for (int s = 0; s < 4; s++) begin
         in_valid = 1'b1; in_select = 2'(s); in_data = pat[s];
         tick;
      end
      in_valid = 1'b0;
      #1;
      chk("fan_valid", 0, 32'(out_valid), 32'hf);
      for (int c = 0; c < 4; c++) chk("fan_data", c, out_data[c*WIDTH +: WIDTH], pat[c]);

      // 3: fill ch1, refuse third word, drain in order
      out_ready = 4'hf;
      tick;
      out_ready = 4'h0;
      in_valid = 1'b1; in_select = 2'd1; in_data = 32'h11111111;
      tick;
      in_data = 32'h22222222;
      tick;
      in_data = 32'h33333333;
      #1;
      chk("full1", 1, 32'(out_full[1]), 32'h1);
      chk("full1_ready", 1, 32'(in_ready), 32'h0);
      tick;
      in_valid = 1'b0; out_ready = 4'b0010;
      #1;
      chk("drain1_a", 1, out_data[1*WIDTH +: WIDTH], 32'h11111111);
      tick;
      chk("drain1_b", 1, out_data[1*WIDTH +: WIDTH], 32'h22222222);
      tick;
      chk("drain1_empty", 1, 32'(out_valid[1]), 32'h0);
      out_ready = 4'h0;

      // 4: simultaneous push and pop on ch2
      in_valid = 1'b1; in_select = 2'd2; in_data = 32'h12345678;
      tick;
      in_data = 32'habcdefff; out_ready = 4'b0100;
      tick;
      in_valid = 1'b0; out_ready = 4'h0;
      #1;
      chk("pp2_valid", 2, 32'(out_valid[2]), 32'h1);
      chk("pp2_full", 2, 32'(out_full[2]), 32'h0);
      chk("pp2_data", 2, out_data[2*WIDTH +: WIDTH], 32'habcdefff);
      out_ready = 4'b0100;
      tick;
      out_ready = 4'h0;

      // 5: push to full ch0 while it pops
      in_valid = 1'b1; in_select = 2'd0; in_data = 32'h00000001;
      tick;
      in_data = 32'h00000002;
      tick;
      in_data = 32'h00000003; out_ready = 4'b0001;
      #1;
      chk("nobypass_ready", 0, 32'(in_ready), 32'h0);
      tick;
      out_ready = 4'h0;
      #1;
      chk("bubble_ready", 0, 32'(in_ready), 32'h1);
      chk("bubble_data", 0, out_data[0 +: WIDTH], 32'h00000002);
      in_valid = 1'b0; out_ready = 4'hf;
      tick; tick;
      out_ready = 4'h0;

      // 6: random traffic with producer hold and a mid-run async reset
      pend = 1'b0;
      for (int n = 0; n < 10000; n++) begin
         if (n == 5000) begin
            reset_n = 1'b0;
            #1;
            chk("midrst_valid", 0, 32'(out_valid), 32'h0);
            chk("midrst_full", 0, 32'(out_full), 32'h0);
            tick;
            reset_n = 1'b1;
            pend = 1'b0;
         end
         if (!pend) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            in_select = 2'($urandom_range(0, 3));
            in_data   = $urandom;
         end
         out_ready = 4'($urandom_range(0, 15));
         pend = in_valid && (mq[in_select].size() >= DEPTH);
         tick;
      end
      in_valid = 1'b0; out_ready = 4'h0;
      tick;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
